// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam int unsigned MS_W  = 10;
  localparam int unsigned SEC_W = 6;

  localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  // Rising edge of an already-debounced button level against its previous sample.
  function automatic logic rise(input logic now, input logic prev);
    return now & ~prev;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Button inputs and display-side outputs of the stopwatch core.
interface stopwatch_core_if;
  import stopwatch_pkg::*;

  logic             start_stop;
  logic             clear;
  logic             lap;
  logic [SEC_W-1:0] seconds;
  logic [MS_W-1:0]  milliseconds;
  logic             refresh_tick;
  logic             running;
  logic             lap_active;
  logic             rollover;

  // Button/driver side.
  modport master (
    output start_stop, clear, lap,
    input  seconds, milliseconds, refresh_tick, running, lap_active, rollover
  );

  // Stopwatch core side.
  modport slave (
    input  start_stop, clear, lap,
    output seconds, milliseconds, refresh_tick, running, lap_active, rollover
  );

endinterface

// File: rtl/stopwatch_core_tick_gen.sv
// Enable-gated modulo-DIV prescaler producing a one-cycle tick on its last count.
module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("tick_gen: DIV must be at least 2");
  end

  logic [W-1:0] cnt;

  // Phase counter: clear wins over enable; holds its phase while disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Gated so a phase parked on LAST while disabled does not leak a tick.
  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: button edge detection, IDLE/RUNNING/PAUSED FSM,
// ms/sec counters, lap freeze and the free-running display refresh enable.
module stopwatch_core #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 1_000,
  parameter int unsigned REFRESH_HZ = 1_000
) (
  input logic             clk,
  input logic             reset,
  stopwatch_core_if.slave bus
);
  import stopwatch_pkg::*;

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_R = CLK_HZ / REFRESH_HZ;

  if ((CLK_HZ % TICK_HZ) != 0 || (CLK_HZ % REFRESH_HZ) != 0) begin : g_rate_check
    $error("stopwatch_core: CLK_HZ must be an exact multiple of TICK_HZ and REFRESH_HZ");
  end

  state_t           state, state_nx;
  logic             ss_q, clr_q, lap_q;
  logic             ss_edge, clr_edge, lap_edge;
  logic             is_running, cnt_clr, cnt_tick, refresh_pulse;

  logic [MS_W-1:0]  ms_cnt, ms_nx, lap_ms, lap_ms_nx;
  logic [SEC_W-1:0] sec_cnt, sec_nx, lap_sec, lap_sec_nx;
  logic             lap_on, lap_on_nx;
  logic             roll_q, roll_nx;

  // Previous button samples for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ss_q  <= 1'b0;
      clr_q <= 1'b0;
      lap_q <= 1'b0;
    end else begin
      ss_q  <= bus.start_stop;
      clr_q <= bus.clear;
      lap_q <= bus.lap;
    end
  end

  assign ss_edge  = rise(bus.start_stop, ss_q);
  assign clr_edge = rise(bus.clear, clr_q);
  assign lap_edge = rise(bus.lap, lap_q);

  assign is_running = (state == RUNNING);
  // A fresh start from IDLE restarts the ms phase; resuming from PAUSED keeps it.
  assign cnt_clr    = clr_edge | ((state == IDLE) & ss_edge);

  tick_gen #(.DIV(DIV)) u_count_tick (
    .clk   (clk),
    .reset (reset),
    .en    (is_running),
    .clr   (cnt_clr),
    .tick  (cnt_tick)
  );

  tick_gen #(.DIV(DIV_R)) u_refresh_tick (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (refresh_pulse)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: clear outranks start_stop in every state.
  always_comb begin
    state_nx = state;
    if (clr_edge) begin
      state_nx = IDLE;
    end else if (ss_edge) begin
      unique case (state)
        IDLE:    state_nx = RUNNING;
        RUNNING: state_nx = PAUSED;
        PAUSED:  state_nx = RUNNING;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Count and lap next values; a tick on the pausing edge still counts
  // because the decision uses the current RUNNING state.
  always_comb begin
    ms_nx      = ms_cnt;
    sec_nx     = sec_cnt;
    lap_ms_nx  = lap_ms;
    lap_sec_nx = lap_sec;
    lap_on_nx  = lap_on;
    roll_nx    = 1'b0;
    if (clr_edge) begin
      ms_nx     = '0;
      sec_nx    = '0;
      lap_on_nx = 1'b0;
    end else if (is_running) begin
      if (cnt_tick) begin
        if (ms_cnt == MS_MAX) begin
          ms_nx = '0;
          if (sec_cnt == SEC_MAX) begin
            sec_nx  = '0;
            roll_nx = 1'b1;
          end else begin
            sec_nx = sec_cnt + 1'b1;
          end
        end else begin
          ms_nx = ms_cnt + 1'b1;
        end
      end
      if (lap_edge) begin
        if (!lap_on) begin
          lap_ms_nx  = ms_cnt;
          lap_sec_nx = sec_cnt;
          lap_on_nx  = 1'b1;
        end else begin
          lap_on_nx = 1'b0;
        end
      end
    end
  end

  // Live counters, lap snapshot and rollover pulse registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ms_cnt  <= '0;
      sec_cnt <= '0;
      lap_ms  <= '0;
      lap_sec <= '0;
      lap_on  <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      ms_cnt  <= ms_nx;
      sec_cnt <= sec_nx;
      lap_ms  <= lap_ms_nx;
      lap_sec <= lap_sec_nx;
      lap_on  <= lap_on_nx;
      roll_q  <= roll_nx;
    end
  end

  // Display mux selects between two register sets only.
  assign bus.seconds      = lap_on ? lap_sec : sec_cnt;
  assign bus.milliseconds = lap_on ? lap_ms  : ms_cnt;
  assign bus.running      = is_running;
  assign bus.lap_active   = lap_on;
  assign bus.rollover     = roll_q;
  assign bus.refresh_tick = refresh_pulse;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core at CLK_HZ=10k (DIV=10, DIV_R=5).
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  stopwatch_core_if bus ();

  stopwatch_core #(
    .CLK_HZ     (10_000),
    .TICK_HZ    (1_000),
    .REFRESH_HZ (2_000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned at;
    int unsigned sec;
    int unsigned ms;
    logic        run;
    logic        lap;
    logic        roll;
    logic        rfr;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks   = 0;
  int unsigned passed   = 0;
  int unsigned cyc_n    = 0;
  int unsigned rst_base = 0;

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  // Refresh prescaler model: free-running from reset release, tick on phase 4 of 5.
  function automatic logic exp_rfr(input int unsigned at);
    return ((at - rst_base) % 5) == 4;
  endfunction

  task automatic expect_at(input string tag, input int unsigned at, input int unsigned sec,
                           input int unsigned ms, input logic run, input logic lap,
                           input logic roll = 1'b0);
    exp_t e;
    e.tag = tag; e.at = at; e.sec = sec; e.ms = ms;
    e.run = run; e.lap = lap; e.roll = roll; e.rfr = exp_rfr(at);
    sb.push_back(e);
  endtask

  // Clear, then a one-cycle start_stop: returns on the first RUNNING sample, phase 0.
  task automatic restart();
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0; bus.start_stop = 1'b1;
    step();
    bus.start_stop = 1'b0;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [19:0] rfr_seen, rfr_want;
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    reset = 1'b0;
    e.tag = "reset_hold"; e.at = 3; e.sec = 0; e.ms = 0;
    e.run = 1'b0; e.lap = 1'b0; e.roll = 1'b0; e.rfr = 1'b0;
    sb.push_back(e);
    for (int unsigned r = 0; r <= 3; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      if (r != 3) step();
    end
    checks++;
    if (dut.state !== IDLE) $display("FAIL reset_state: got %0d, required %0d", dut.state, IDLE);
    else passed++;

    reset = 1'b1;
    rst_base = cyc_n;
    expect_at("reset_release", rst_base + 1, 0, 0, 1'b0, 1'b0);
    expect_at("refresh_first", rst_base + 4, 0, 0, 1'b0, 1'b0);
    rfr_seen = '0;
    for (int unsigned r = 0; r <= 20; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      if (r >= 1) rfr_seen[r-1] = bus.refresh_tick;
      if (r != 20) step();
    end
    for (int i = 0; i < 20; i++) rfr_want[i] = ((i + 1) % 5) == 4;
    checks++;
    if (rfr_seen !== rfr_want) $display("FAIL refresh_pattern: got %b, required %b", rfr_seen, rfr_want);
    else passed++;
  endtask

  task automatic test_run();
    exp_t        e;
    int unsigned b;
    restart();
    b = cyc_n;
    expect_at("run_start", b,         0, 0,   1'b1, 1'b0);
    expect_at("run_pre1",  b + 9,     0, 0,   1'b1, 1'b0);
    expect_at("run_1ms",   b + 10,    0, 1,   1'b1, 1'b0);
    expect_at("run_1233",  b + 12339, 1, 233, 1'b1, 1'b0);
    expect_at("run_1234",  b + 12340, 1, 234, 1'b1, 1'b0);
    for (int unsigned r = 0; r <= 12340; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      if (r != 12340) step();
    end
  endtask

  task automatic test_rollover();
    exp_t        e;
    int unsigned b, hits, first;
    restart();
    b = cyc_n;
    force dut.ms_cnt  = 10'd998;
    force dut.sec_cnt = 6'd59;
    step();
    release dut.ms_cnt;
    release dut.sec_cnt;
    expect_at("roll_preload", b + 1,  59, 998, 1'b1, 1'b0);
    expect_at("roll_999",     b + 10, 59, 999, 1'b1, 1'b0);
    expect_at("roll_pre",     b + 19, 59, 999, 1'b1, 1'b0);
    expect_at("roll_wrap",    b + 20, 0,  0,   1'b1, 1'b0, 1'b1);
    expect_at("roll_after",   b + 21, 0,  0,   1'b1, 1'b0);
    hits = 0; first = 0;
    for (int unsigned r = 1; r <= 21; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      if (bus.rollover === 1'b1) begin
        hits++;
        if (first == 0) first = r;
      end
      if (r != 21) step();
    end
    checks++;
    if (hits != 1 || first != 20)
      $display("FAIL roll_pulse: got %0d pulses first at %0d, required 1 pulse at 20", hits, first);
    else passed++;
  endtask

  task automatic test_pause();
    exp_t        e;
    int unsigned b;
    restart();
    b = cyc_n;
    expect_at("pause_pre",       b + 50,  0, 5, 1'b1, 1'b0);
    expect_at("pause_enter",     b + 53,  0, 5, 1'b0, 1'b0);
    expect_at("pause_100",       b + 153, 0, 5, 1'b0, 1'b0);
    expect_at("resume",          b + 154, 0, 5, 1'b1, 1'b0);
    expect_at("resume_pre",      b + 160, 0, 5, 1'b1, 1'b0);
    expect_at("resume_phase",    b + 161, 0, 6, 1'b1, 1'b0);
    expect_at("tick_pause_pre",  b + 170, 0, 6, 1'b1, 1'b0);
    expect_at("tick_pause",      b + 171, 0, 7, 1'b0, 1'b0);
    expect_at("tick_pause_hold", b + 175, 0, 7, 1'b0, 1'b0);
    for (int unsigned r = 0; r <= 175; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      case (r)
        52:      bus.start_stop = 1'b1;
        82:      bus.start_stop = 1'b0;
        153:     bus.start_stop = 1'b1;
        154:     bus.start_stop = 1'b0;
        170:     bus.start_stop = 1'b1;
        171:     bus.start_stop = 1'b0;
        default: ;
      endcase
      if (r != 175) step();
    end
  endtask

  task automatic test_lap();
    exp_t        e;
    int unsigned b;
    restart();
    b = cyc_n;
    expect_at("lap_pre",         b + 1000, 0, 100, 1'b1, 1'b0);
    expect_at("lap_latch",       b + 1001, 0, 100, 1'b1, 1'b1);
    expect_at("lap_frozen",      b + 1501, 0, 100, 1'b1, 1'b1);
    expect_at("lap_release",     b + 1502, 0, 150, 1'b1, 1'b0);
    expect_at("lap_again",       b + 1506, 0, 150, 1'b1, 1'b1);
    expect_at("lap_paused",      b + 1507, 0, 150, 1'b0, 1'b1);
    expect_at("lap_paused_edge", b + 1509, 0, 150, 1'b0, 1'b1);
    expect_at("lap_paused_hold", b + 1510, 0, 150, 1'b0, 1'b1);
    for (int unsigned r = 0; r <= 1510; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      case (r)
        1000:    bus.lap = 1'b1;
        1001:    bus.lap = 1'b0;
        1501:    bus.lap = 1'b1;
        1502:    bus.lap = 1'b0;
        1505:    bus.lap = 1'b1;
        1506:    begin bus.lap = 1'b0; bus.start_stop = 1'b1; end
        1507:    bus.start_stop = 1'b0;
        1508:    bus.lap = 1'b1;
        1509:    bus.lap = 1'b0;
        default: ;
      endcase
      if (r != 1510) step();
    end
  endtask

  task automatic test_clear_priority();
    exp_t        e;
    int unsigned b;
    restart();
    b = cyc_n;
    expect_at("clr_pre_lap",   b + 30, 0, 3, 1'b1, 1'b0);
    expect_at("clr_lap_on",    b + 31, 0, 3, 1'b1, 1'b1);
    expect_at("clr_lap_hold",  b + 44, 0, 3, 1'b1, 1'b1);
    expect_at("clr_wins",      b + 46, 0, 0, 1'b0, 1'b0);
    expect_at("clr_held_ss",   b + 66, 0, 0, 1'b0, 1'b0);
    expect_at("clr_idle_lap",  b + 71, 0, 0, 1'b0, 1'b0);
    expect_at("clr_idle_hold", b + 72, 0, 0, 1'b0, 1'b0);
    for (int unsigned r = 0; r <= 72; r++) begin
      while (sb.size() != 0 && sb[0].at == cyc_n) begin
        e = sb.pop_front();
        checks++;
        if (bus.seconds !== 6'(e.sec) || bus.milliseconds !== 10'(e.ms) ||
            bus.running !== e.run || bus.lap_active !== e.lap ||
            bus.rollover !== e.roll || bus.refresh_tick !== e.rfr)
          $display("FAIL %s: got %0d.%03d run=%b lap=%b roll=%b rfr=%b, required %0d.%03d run=%b lap=%b roll=%b rfr=%b",
                   e.tag, bus.seconds, bus.milliseconds, bus.running, bus.lap_active, bus.rollover,
                   bus.refresh_tick, e.sec, e.ms, e.run, e.lap, e.roll, e.rfr);
        else passed++;
      end
      case (r)
        30:      bus.lap = 1'b1;
        31:      bus.lap = 1'b0;
        45:      begin bus.clear = 1'b1; bus.start_stop = 1'b1; end
        46:      bus.clear = 1'b0;
        66:      bus.start_stop = 1'b0;
        70:      bus.lap = 1'b1;
        71:      bus.lap = 1'b0;
        default: ;
      endcase
      if (r != 72) step();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_rollover();
    test_pause();
    test_lap();
    test_clear_priority();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "time limit");
  end

endmodule
